// File: rtl/store_fwd_queue.sv
// Store queue: holds dispatched stores until the ROB commits them, forwards their bytes to
// younger loads, and drains committed stores to dmem one at a time in program order.
module store_fwd_queue #(
  parameter int SQ_DEPTH    = 8,
  parameter int ROB_ID_BITS = 5,
  localparam int PTR_BITS   = $clog2(SQ_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   alloc_valid,
  input  logic [ROB_ID_BITS-1:0] alloc_rob_id,
  output logic                   alloc_ready,
  output logic [PTR_BITS-1:0]    alloc_ptr,
  input  logic                   fill_valid,
  input  logic [PTR_BITS-1:0]    fill_ptr,
  input  logic [31:0]            fill_addr,
  input  logic [31:0]            fill_data,
  input  logic [2:0]             fill_funct3,
  input  logic                   commit_valid,
  input  logic                   flush,
  input  logic                   ld_valid,
  input  logic [31:0]            ld_addr,
  input  logic [2:0]             ld_funct3,
  input  logic [PTR_BITS-1:0]    ld_sq_ptr,
  output logic                   ld_resp_valid,
  output logic                   ld_hit,
  output logic                   ld_stall,
  output logic [31:0]            ld_data,
  output logic                   dmem_wvalid,
  output logic [31:0]            dmem_waddr,
  output logic [3:0]             dmem_wmask,
  output logic [31:0]            dmem_wdata,
  input  logic                   dmem_wresp
);

  localparam int IDX_BITS = PTR_BITS - 1;
  localparam logic [PTR_BITS-1:0] PTR_ONE = 1;

  typedef enum logic {IDLE, REQ} drain_state_t;
  drain_state_t state, state_next;

  logic [PTR_BITS-1:0] head, cmt, tail;
  logic [IDX_BITS-1:0] head_idx, tail_idx, cmt_idx, fill_idx;
  logic [SQ_DEPTH-1:0] ent_valid, ent_filled, ent_committed;
  logic [29:0]         ent_waddr [SQ_DEPTH];
  logic [3:0]          ent_wmask [SQ_DEPTH];
  logic [31:0]         ent_wdata [SQ_DEPTH];

  logic full, do_alloc, do_fill, do_commit, pop, head_ready;
  logic [3:0]  fill_mask;
  logic [31:0] fill_lanes;

  // The ROB id travels with the store elsewhere; the queue itself only needs the ordering.
  logic unused_rob_id;
  assign unused_rob_id = ^alloc_rob_id;

  assign head_idx = head[IDX_BITS-1:0];
  assign tail_idx = tail[IDX_BITS-1:0];
  assign cmt_idx  = cmt[IDX_BITS-1:0];
  assign fill_idx = fill_ptr[IDX_BITS-1:0];

  assign full        = (head_idx == tail_idx) && (head[IDX_BITS] != tail[IDX_BITS]);
  assign alloc_ready = !full;
  assign alloc_ptr   = tail;

  assign do_alloc   = alloc_valid && alloc_ready && !flush;
  assign do_fill    = fill_valid && !flush;
  assign do_commit  = commit_valid && !flush;
  assign pop        = (state == REQ) && dmem_wresp;
  assign head_ready = ent_valid[head_idx] && ent_filled[head_idx] && ent_committed[head_idx];

  always_comb begin
    fill_mask  = 4'b1111;
    fill_lanes = fill_data;
    case (fill_funct3)
      3'b000: begin
        fill_mask  = 4'b0001 << fill_addr[1:0];
        fill_lanes = {4{fill_data[7:0]}};
      end
      3'b001: begin
        fill_mask  = 4'b0011 << fill_addr[1:0];
        fill_lanes = {2{fill_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Flush rewinds the tail to the commit pointer; a pop only ever moves the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      if (pop) head <= head + PTR_ONE;
      if (flush) begin
        tail <= cmt;
      end else begin
        if (do_alloc)  tail <= tail + PTR_ONE;
        if (do_commit) cmt  <= cmt + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid     <= '0;
      ent_filled    <= '0;
      ent_committed <= '0;
    end else begin
      for (int i = 0; i < SQ_DEPTH; i++) begin
        if (pop && head_idx == IDX_BITS'(i)) begin
          ent_valid[i]     <= 1'b0;
          ent_filled[i]    <= 1'b0;
          ent_committed[i] <= 1'b0;
        end else if (flush) begin
          if (!ent_committed[i]) begin
            ent_valid[i]  <= 1'b0;
            ent_filled[i] <= 1'b0;
          end
        end else begin
          if (do_alloc && tail_idx == IDX_BITS'(i)) begin
            ent_valid[i]     <= 1'b1;
            ent_filled[i]    <= 1'b0;
            ent_committed[i] <= 1'b0;
          end
          if (do_fill && fill_idx == IDX_BITS'(i)) ent_filled[i] <= 1'b1;
          if (do_commit && cmt_idx == IDX_BITS'(i)) ent_committed[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_fill) begin
      ent_waddr[fill_idx] <= fill_addr[31:2];
      ent_wmask[fill_idx] <= fill_mask;
      ent_wdata[fill_idx] <= fill_lanes;
    end
  end

  logic [PTR_BITS-1:0] ld_dist;
  logic [IDX_BITS-1:0] cand_idx;
  logic [3:0]  rmask, covered;
  logic [31:0] merged, shifted, extended;
  logic        unresolved, all_cov, hit_c, stall_c;

  // Walk candidates oldest to youngest so the youngest matching store wins each byte lane.
  always_comb begin
    rmask = 4'b1111;
    case (ld_funct3[1:0])
      2'b00:   rmask = 4'b0001 << ld_addr[1:0];
      2'b01:   rmask = 4'b0011 << ld_addr[1:0];
      default: ;
    endcase
    ld_dist    = ld_sq_ptr - head;
    cand_idx   = head_idx;
    unresolved = 1'b0;
    covered    = '0;
    merged     = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      cand_idx = head_idx + IDX_BITS'(k);
      if (PTR_BITS'(k) < ld_dist && ent_valid[cand_idx]) begin
        if (!ent_filled[cand_idx]) begin
          unresolved = 1'b1;
        end else if (ent_waddr[cand_idx] == ld_addr[31:2]) begin
          for (int b = 0; b < 4; b++) begin
            if (ent_wmask[cand_idx][b]) begin
              covered[b]      = 1'b1;
              merged[8*b +: 8] = ent_wdata[cand_idx][8*b +: 8];
            end
          end
        end
      end
    end
    shifted = merged >> {ld_addr[1:0], 3'b000};
    case (ld_funct3)
      3'b000:  extended = {{24{shifted[7]}}, shifted[7:0]};
      3'b100:  extended = {24'b0, shifted[7:0]};
      3'b001:  extended = {{16{shifted[15]}}, shifted[15:0]};
      3'b101:  extended = {16'b0, shifted[15:0]};
      default: extended = shifted;
    endcase
    all_cov = ((covered & rmask) == rmask);
    hit_c   = !unresolved && all_cov;
    stall_c = unresolved || (|(covered & rmask) && !all_cov);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_resp_valid <= 1'b0;
      ld_hit        <= 1'b0;
      ld_stall      <= 1'b0;
      ld_data       <= '0;
    end else begin
      ld_resp_valid <= ld_valid && !flush;
      ld_hit        <= ld_valid && !flush && hit_c;
      ld_stall      <= ld_valid && !flush && stall_c;
      ld_data       <= (ld_valid && !flush && hit_c) ? extended : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (head_ready) state_next = REQ;
      REQ:  if (dmem_wresp) state_next = IDLE;
    endcase
  end

  always_comb begin
    dmem_wvalid = (state == REQ);
  end

  // Payload is captured once on entering REQ and held until the write is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dmem_waddr <= '0;
      dmem_wmask <= '0;
      dmem_wdata <= '0;
    end else if (state == IDLE && head_ready) begin
      dmem_waddr <= {ent_waddr[head_idx], 2'b00};
      dmem_wmask <= ent_wmask[head_idx];
      dmem_wdata <= ent_wdata[head_idx];
    end
  end

endmodule

// File: tb/tb_store_fwd_queue.sv
// Bench for store_fwd_queue: directed and randomized traffic against a byte-address store-list
// model; load responses and dmem writes are popped from scoreboard queues by a monitor.
module tb_store_fwd_queue;
  localparam int DEPTH = 8;
  localparam int PB    = 4;
  localparam int PMOD  = 2 * DEPTH;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          alloc_valid = 1'b0;
  logic [4:0]    alloc_rob_id = '0;
  logic          alloc_ready;
  logic [PB-1:0] alloc_ptr;
  logic          fill_valid = 1'b0;
  logic [PB-1:0] fill_ptr = '0;
  logic [31:0]   fill_addr = '0;
  logic [31:0]   fill_data = '0;
  logic [2:0]    fill_funct3 = '0;
  logic          commit_valid = 1'b0;
  logic          flush = 1'b0;
  logic          ld_valid = 1'b0;
  logic [31:0]   ld_addr = '0;
  logic [2:0]    ld_funct3 = '0;
  logic [PB-1:0] ld_sq_ptr = '0;
  logic          ld_resp_valid, ld_hit, ld_stall;
  logic [31:0]   ld_data;
  logic          dmem_wvalid;
  logic [31:0]   dmem_waddr, dmem_wdata;
  logic [3:0]    dmem_wmask;
  logic          dmem_wresp = 1'b0;

  store_fwd_queue #(.SQ_DEPTH(DEPTH), .ROB_ID_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_rob_id(alloc_rob_id),
    .alloc_ready(alloc_ready), .alloc_ptr(alloc_ptr),
    .fill_valid(fill_valid), .fill_ptr(fill_ptr), .fill_addr(fill_addr),
    .fill_data(fill_data), .fill_funct3(fill_funct3),
    .commit_valid(commit_valid), .flush(flush),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_funct3(ld_funct3), .ld_sq_ptr(ld_sq_ptr),
    .ld_resp_valid(ld_resp_valid), .ld_hit(ld_hit), .ld_stall(ld_stall), .ld_data(ld_data),
    .dmem_wvalid(dmem_wvalid), .dmem_waddr(dmem_waddr), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_wresp(dmem_wresp)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          ptr;
    int          size;
    bit          filled;
    bit          committed;
    logic [31:0] addr;
    logic [31:0] data;
  } st_t;
  typedef struct { logic hit; logic stall; logic [31:0] data; } ld_exp_t;
  typedef struct { logic [31:0] waddr; logic [3:0] mask; logic [31:0] data; } wr_exp_t;

  st_t     mq[$];
  ld_exp_t lq[$];
  wr_exp_t wq[$];
  int mhead = 0, mtail = 0;
  int total = 0, bad = 0;
  int wlat = 0, wseen = 0;
  ld_exp_t le;
  wr_exp_t we;
  logic [31:0] bm;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Expected load result from byte addresses covered by older stores, youngest first.
  function automatic ld_exp_t model_load(input logic [31:0] a, input logic [2:0] f3, input int sp);
    ld_exp_t r;
    int n, size, ncov;
    bit unres, found;
    logic [31:0] val, ba;
    n    = (sp - mhead + PMOD) % PMOD;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    unres = 0;
    for (int i = 0; i < n; i++) if (!mq[i].filled) unres = 1;
    ncov = 0;
    val  = '0;
    for (int j = 0; j < size; j++) begin
      ba = a + 32'(j);
      found = 0;
      for (int i = n - 1; i >= 0 && !found; i--) begin
        if (mq[i].filled && ba >= mq[i].addr && ba < mq[i].addr + 32'(mq[i].size)) begin
          val[8*j +: 8] = mq[i].data[8*(ba - mq[i].addr) +: 8];
          found = 1;
        end
      end
      if (found) ncov++;
    end
    r.hit   = !unres && (ncov == size);
    r.stall = unres || (ncov > 0 && ncov < size);
    r.data  = '0;
    if (r.hit) begin
      if (size == 1)      r.data = f3[2] ? {24'b0, val[7:0]} : {{24{val[7]}}, val[7:0]};
      else if (size == 2) r.data = f3[2] ? {16'b0, val[15:0]} : {{16{val[15]}}, val[15:0]};
      else                r.data = val;
    end
    return r;
  endfunction

  // One clock cycle: checks queue status, answers dmem, updates the model, advances time.
  task automatic apply_stimulus();
    int fu;
    wr_exp_t w;
    check_output("alloc_ready", {31'b0, alloc_ready}, {31'b0, mq.size() < DEPTH});
    check_output("alloc_ptr", {28'b0, alloc_ptr}, mtail);
    dmem_wresp = 1'b0;
    if (dmem_wvalid) begin
      if (wseen >= wlat) begin dmem_wresp = 1'b1; wseen = 0; end
      else wseen++;
    end
    if (ld_valid && !flush) lq.push_back(model_load(ld_addr, ld_funct3, int'(ld_sq_ptr)));
    if (dmem_wresp && mq.size() > 0) begin
      w.waddr = {mq[0].addr[31:2], 2'b00};
      w.mask  = '0;
      w.data  = '0;
      for (int j = 0; j < mq[0].size; j++) begin
        w.mask[int'(mq[0].addr[1:0]) + j] = 1'b1;
        w.data[8*(int'(mq[0].addr[1:0]) + j) +: 8] = mq[0].data[8*j +: 8];
      end
      wq.push_back(w);
    end
    if (flush) begin
      fu = -1;
      for (int i = 0; i < mq.size() && fu < 0; i++) if (!mq[i].committed) fu = i;
      if (fu >= 0) begin
        mtail = mq[fu].ptr;
        while (mq.size() > fu) void'(mq.pop_back());
      end
    end else begin
      if (alloc_valid && mq.size() < DEPTH) begin
        mq.push_back('{ptr: mtail, size: 0, filled: 0, committed: 0, addr: '0, data: '0});
        mtail = (mtail + 1) % PMOD;
      end
      if (fill_valid) begin
        foreach (mq[i]) if (mq[i].ptr == int'(fill_ptr)) begin
          mq[i].filled = 1;
          mq[i].addr   = fill_addr;
          mq[i].data   = fill_data;
          mq[i].size   = (fill_funct3[1:0] == 2'b00) ? 1 : (fill_funct3[1:0] == 2'b01) ? 2 : 4;
        end
      end
      if (commit_valid) begin
        fu = -1;
        for (int i = 0; i < mq.size() && fu < 0; i++) if (!mq[i].committed) fu = i;
        if (fu >= 0) mq[fu].committed = 1;
      end
    end
    if (dmem_wresp && mq.size() > 0) begin
      void'(mq.pop_front());
      mhead = (mhead + 1) % PMOD;
    end
    @(posedge clk);
    #1;
    alloc_valid = 0; fill_valid = 0; commit_valid = 0; flush = 0; ld_valid = 0;
  endtask

  task automatic stage_fill(input int ptr, input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
    fill_valid = 1; fill_ptr = PB'(ptr); fill_addr = a; fill_data = d; fill_funct3 = f3;
  endtask

  task automatic stage_query(input logic [31:0] a, input logic [2:0] f3, input int sp);
    ld_valid = 1; ld_addr = a; ld_funct3 = f3; ld_sq_ptr = PB'(sp);
  endtask

  task automatic stage_random_fill(input int ptr);
    logic [2:0]  f3;
    logic [31:0] a;
    f3 = 3'($urandom_range(0, 2));
    a  = 32'h4000 + 32'($urandom_range(0, 15));
    if (f3 == 3'b010) a[1:0] = 2'b00;
    if (f3 == 3'b001) a[0] = 1'b0;
    stage_fill(ptr, a, $urandom, f3);
  endtask

  task automatic stage_random_query();
    logic [2:0]  f3;
    logic [31:0] a;
    int sel;
    sel = $urandom_range(0, 4);
    f3  = (sel == 0) ? 3'b000 : (sel == 1) ? 3'b100 : (sel == 2) ? 3'b001 : (sel == 3) ? 3'b101 : 3'b010;
    a   = 32'h4000 + 32'($urandom_range(0, 15));
    if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
    if (f3[1:0] == 2'b01) a[0] = 1'b0;
    stage_query(a, f3, (mhead + $urandom_range(0, mq.size())) % PMOD);
  endtask

  task automatic drain_all();
    for (int c = 0; c < 400 && mq.size() > 0; c++) begin
      for (int i = 0; i < mq.size(); i++) if (!mq[i].filled) begin
        stage_random_fill(mq[i].ptr);
        break;
      end
      foreach (mq[i]) if (!mq[i].committed) commit_valid = 1;
      if (!dmem_wvalid) wlat = $urandom_range(0, 2);
      apply_stimulus();
    end
    check_output("drain_empty", mq.size(), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (ld_resp_valid) begin
        if (lq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL ld_resp_unexpected: got ld_resp_valid=1 expected no response");
        end else begin
          le = lq.pop_front();
          check_output("ld_hit", {31'b0, ld_hit}, {31'b0, le.hit});
          check_output("ld_stall", {31'b0, ld_stall}, {31'b0, le.stall});
          if (le.hit) check_output("ld_data", ld_data, le.data);
        end
      end
      if (dmem_wvalid && dmem_wresp) begin
        if (wq.size() == 0) begin
          total++; bad++;
          $display("[TB] FAIL dmem_write_unexpected: got write to 0x%08h expected none", dmem_waddr);
        end else begin
          we = wq.pop_front();
          for (int b = 0; b < 4; b++) bm[8*b +: 8] = {8{we.mask[b]}};
          check_output("dmem_waddr", dmem_waddr, we.waddr);
          check_output("dmem_wmask", {28'b0, dmem_wmask}, {28'b0, we.mask});
          check_output("dmem_wdata", dmem_wdata & bm, we.data & bm);
        end
      end
    end
  end

  initial begin
    int pa, pb, pu, pm, cnt;
    repeat (2) @(posedge clk);
    #1;
    check_output("rst_alloc_ready", {31'b0, alloc_ready}, 32'd1);
    check_output("rst_alloc_ptr", {28'b0, alloc_ptr}, 32'd0);
    check_output("rst_ld_resp_valid", {31'b0, ld_resp_valid}, 32'd0);
    check_output("rst_ld_data", ld_data, 32'd0);
    check_output("rst_dmem_wvalid", {31'b0, dmem_wvalid}, 32'd0);
    check_output("rst_dmem_wmask", {28'b0, dmem_wmask}, 32'd0);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;

    // Single word store: same-cycle fill is invisible, next query forwards, empty set misses.
    pa = mtail;
    alloc_valid = 1; apply_stimulus();
    stage_fill(pa, 32'h1000, 32'hDEADBEEF, 3'b010);
    stage_query(32'h1000, 3'b010, mtail);
    apply_stimulus();
    stage_query(32'h1000, 3'b010, mtail); apply_stimulus();
    stage_query(32'h1000, 3'b010, mhead); apply_stimulus();

    // Two stores merged per byte: older word plus younger byte.
    pa = mtail; alloc_valid = 1; apply_stimulus();
    pb = mtail; alloc_valid = 1; apply_stimulus();
    stage_fill(pa, 32'h2000, 32'h11223344, 3'b010); apply_stimulus();
    stage_fill(pb, 32'h2001, 32'h123456AA, 3'b000); apply_stimulus();
    stage_query(32'h2000, 3'b101, mtail); apply_stimulus();
    stage_query(32'h2001, 3'b000, mtail); apply_stimulus();
    stage_query(32'h2000, 3'b101, pb); apply_stimulus();

    // Partial coverage and an unresolved older store both force a retry.
    pa = mtail; alloc_valid = 1; apply_stimulus();
    stage_fill(pa, 32'h3000, 32'h00000055, 3'b000); apply_stimulus();
    stage_query(32'h3000, 3'b010, mtail); apply_stimulus();
    pu = mtail; alloc_valid = 1; apply_stimulus();
    pm = mtail; alloc_valid = 1; apply_stimulus();
    stage_fill(pm, 32'h5000, 32'hCAFEF00D, 3'b010); apply_stimulus();
    stage_query(32'h5000, 3'b010, mtail); apply_stimulus();
    stage_query(32'h6000, 3'b010, pu); apply_stimulus();

    // Fill up, attempt one alloc while full, then drain with a slow dmem.
    pa = mtail; alloc_valid = 1; apply_stimulus();
    pb = mtail; alloc_valid = 1; apply_stimulus();
    alloc_valid = 1; apply_stimulus();
    stage_fill(pu, 32'h5002, 32'h00009999, 3'b001); apply_stimulus();
    stage_fill(pa, 32'h6000, 32'h01020304, 3'b010); apply_stimulus();
    stage_fill(pb, 32'h6003, 32'h000000F0, 3'b000); apply_stimulus();
    wlat = 2; wseen = 0;
    commit_valid = 1; apply_stimulus();
    commit_valid = 1; apply_stimulus();
    for (int i = 0; i < 10 && !dmem_wvalid; i++) apply_stimulus();
    check_output("drain_started", {31'b0, dmem_wvalid}, 32'd1);
    cnt = 0;
    while (dmem_wvalid && cnt < 10) begin cnt++; apply_stimulus(); end
    check_output("drain_hold_cycles", cnt, 32'd3);
    for (int i = 0; i < 6; i++) begin
      alloc_valid = 1;
      stage_query(32'h5000, 3'b010, mtail);
      apply_stimulus();
    end
    stage_query(32'h6000, 3'b010, mtail); apply_stimulus();
    stage_query(32'h6003, 3'b000, mtail); apply_stimulus();

    // Randomized mix across many pointer wraps.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 2) != 0 && mq.size() < DEPTH) begin
        alloc_valid = 1; alloc_rob_id = 5'($urandom);
      end
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < mq.size(); i++) if (!mq[i].filled && $urandom_range(0, 1) == 1) begin
          stage_random_fill(mq[i].ptr);
          break;
        end
      end
      if ($urandom_range(0, 3) == 0) foreach (mq[i]) if (!mq[i].committed) commit_valid = 1;
      if ($urandom_range(0, 1) == 1) stage_random_query();
      if ($urandom_range(0, 39) == 0) flush = 1;
      if (!dmem_wvalid) wlat = $urandom_range(0, 2);
      apply_stimulus();
    end
    drain_all();

    // Flush with three allocated and one committed; the committed store still drains.
    wlat = 3; wseen = 0;
    pa = mtail; alloc_valid = 1; apply_stimulus();
    alloc_valid = 1; apply_stimulus();
    alloc_valid = 1; apply_stimulus();
    stage_fill(pa, 32'h7000, 32'hA5A5_0F0F, 3'b010); apply_stimulus();
    commit_valid = 1; apply_stimulus();
    flush = 1; alloc_valid = 1;
    stage_query(32'h7000, 3'b010, mtail);
    apply_stimulus();
    check_output("flush_tail", {28'b0, alloc_ptr}, (pa + 1) % PMOD);
    for (int i = 0; i < 20 && mq.size() > 0; i++) apply_stimulus();
    check_output("flush_committed_drained", mq.size(), 0);
    stage_query(32'h7000, 3'b010, mtail); apply_stimulus();

    // Asynchronous reset in the middle of a drain.
    pa = mtail; alloc_valid = 1; apply_stimulus();
    stage_fill(pa, 32'h8000, 32'h87654321, 3'b010); apply_stimulus();
    wlat = 5; wseen = 0;
    commit_valid = 1; apply_stimulus();
    for (int i = 0; i < 10 && !dmem_wvalid; i++) apply_stimulus();
    check_output("pre_reset_drain", {31'b0, dmem_wvalid}, 32'd1);
    rst_n = 0;
    #1;
    check_output("mid_reset_wvalid", {31'b0, dmem_wvalid}, 32'd0);
    check_output("mid_reset_alloc_ready", {31'b0, alloc_ready}, 32'd1);
    check_output("mid_reset_alloc_ptr", {28'b0, alloc_ptr}, 32'd0);
    mq.delete(); lq.delete(); wq.delete();
    mhead = 0; mtail = 0; wseen = 0; wlat = 0; dmem_wresp = 0;
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    pa = mtail; alloc_valid = 1; apply_stimulus();
    stage_fill(pa, 32'h9000, 32'h0BADF00D, 3'b010); apply_stimulus();
    stage_query(32'h9002, 3'b001, mtail); apply_stimulus();
    drain_all();
    repeat (3) apply_stimulus();
    check_output("pending_loads", lq.size(), 0);
    check_output("pending_writes", wq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_fwd_queue.md
Name: store_fwd_queue

Overview:
- Parametrised store queue for the out-of-order memory unit.
- Holds in-flight stores from dispatch until committed stores are drained to dmem.
- Answers load queries with byte-granular store-to-load forwarding, merging bytes from multiple older stores.
- Sits between the dispatch/rename stage, the LSU address-generation stage, the ROB commit port and the dmem write port.

Parameters:
SQ_DEPTH, 8, number of entries; power of two, at least 2
ROB_ID_BITS, 5, width of ROB id
PTR_BITS, $clog2(SQ_DEPTH)+1, queue pointer width including wrap bit (derived, not overridden)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
alloc_valid  in  1  dispatch allocates one store entry
alloc_rob_id  in  ROB_ID_BITS  ROB id of the allocated store
alloc_ready  out  1  queue not full
alloc_ptr  out  PTR_BITS  current tail pointer; becomes the new entry's pointer on allocation
fill_valid  in  1  store address/data resolved
fill_ptr  in  PTR_BITS  entry being filled
fill_addr  in  32  byte address
fill_data  in  32  unaligned register data
fill_funct3  in  3  sb/sh/sw
commit_valid  in  1  ROB commits the store at the commit pointer
flush  in  1  squash all uncommitted entries
ld_valid  in  1  load query
ld_addr  in  32  load byte address
ld_funct3  in  3  lb/lbu/lh/lhu/lw
ld_sq_ptr  in  PTR_BITS  tail snapshot at load dispatch; entries before it are older
ld_resp_valid  out  1  registered query response
ld_hit  out  1  all loaded bytes forwarded
ld_stall  out  1  retry: partial coverage or unresolved older store
ld_data  out  32  extended load result, valid when ld_hit
dmem_wvalid  out  1  drain write request
dmem_waddr  out  32  word-aligned address
dmem_wmask  out  4  byte mask
dmem_wdata  out  32  lane-aligned data
dmem_wresp  in  1  write accepted/complete

Behaviour:
- Reset (async, rst_n=0):
  - head, commit and tail pointers reset to 0; all entry valid/filled/committed bits reset to 0.
  - Outputs: alloc_ready=1, alloc_ptr=0, ld_resp_valid=0, ld_hit=0, ld_stall=0, ld_data=0, dmem_wvalid=0, dmem_waddr=0, dmem_wmask=0, dmem_wdata=0.
  - Drain FSM returns to IDLE. Reset mid-drain abandons the request.
- Pointers: PTR_BITS wide, index = low bits.
  - Empty: head==tail.
  - Full: indexes equal and wrap bits differ.
  - alloc_ready = !full, computed from registered state only; no same-cycle bypass of a dequeue.
- Allocate (alloc_valid && alloc_ready): entry[tail] gets valid=1, filled=0, committed=0; tail increments.
- Fill: set filled=1 and store word address, wmask and lane-aligned data for entry[fill_ptr].
  - sb: wmask=1<<addr[1:0], data byte replicated.
  - sh: wmask=3<<addr[1:0] (addr[0]=0 guaranteed), halfword replicated.
  - sw: 1111.
- Commit: entry[commit_ptr] gets committed=1; commit_ptr increments. commit_valid is only asserted when that entry is valid.
- Flush: tail <= commit_ptr and valid cleared for uncommitted entries, next edge. Committed entries and any in-progress drain are untouched. Flush beats alloc, fill and commit in the same cycle, and suppresses the next-cycle ld_resp_valid.
- Drain FSM:
  - IDLE -> REQ when entry[head] is valid, filled and committed; dmem_* registered from the entry.
  - REQ holds dmem_wvalid and payload stable until dmem_wresp.
  - On dmem_wresp: clear entry[head], increment head, return to IDLE. Back-to-back drains therefore take at least 2 cycles each.
  - The draining entry remains visible to load queries until popped.
- Load query, 1-cycle latency (inputs sampled at cycle N, response registered at N+1):
  - rmask derived from ld_funct3/ld_addr[1:0].
  - Candidate set: valid entries from head up to ld_sq_ptr-1, pointer-ordered.
  - If any candidate is unfilled: ld_stall=1, ld_hit=0.
  - Otherwise, per byte b with rmask[b], take the data from the youngest candidate with the same word address and wmask[b].
  - All rmask bytes covered: ld_hit=1, ld_data = merged word shifted and sign/zero-extended per funct3.
  - No bytes covered: ld_hit=0, ld_stall=0; the load goes to memory.
  - Some bytes covered: ld_stall=1.
  - A fill arriving in the same cycle as a query is not seen by that query.
  - ld_sq_ptr==head gives an empty candidate set, i.e. a miss.
- Pointer wrap: all age comparisons use wrap-bit-aware distance from head.

Test Plan:
- Reset mid-drain (dmem_wvalid=1, rst_n low) -> dmem_wvalid=0 immediately; alloc_ready=1; alloc_ptr=0.
- Fill sw 0x1000=0xDEADBEEF; query lw 0x1000 with ld_sq_ptr after it -> next cycle ld_hit=1, ld_data=0xDEADBEEF.
- sw 0x2000=0x11223344, then younger sb 0x2001=0xAA; query lhu 0x2000 -> ld_hit=1, ld_data=0x0000AA44. Query lb 0x2001 -> ld_data=0xFFFFFFAA.
- sb 0x3000=0x55 only; query lw 0x3000 -> ld_stall=1. Older unfilled entry plus matching filled store -> ld_stall=1.
- Fill SQ_DEPTH entries -> alloc_ready=0. Commit 2 and drain 1 with dmem_wresp after 3 cycles -> dmem_wvalid held for 3 cycles; alloc_ready=1 after the pop. Continue allocating across the index wrap; queries remain correct.
- Flush with 3 allocated and 1 committed -> tail=commit_ptr. The committed store still drains. A query issued with the flush gets no ld_resp_valid.
